cycle_sequencer: RTL and testbench

Multi-cycle FSM that sequences the 8-bit accumulator datapath: PC, shift register file, accumulator, ALU, and a single shared instruction/data memory. It fetches instructions over a req/ack memory handshake and latches them in an internal IR. It then decodes the 3-bit opcode / 5-bit immediate and emits one-cycle control strobes per phase. It replaces the purely combinational control unit and arbitrates the one memory port between fetch and load/store.

---
 rtl/cycle_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cycle_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// Multi-cycle control sequencer for the 8-bit accumulator datapath.
// Owns the IR and arbitrates the shared memory port between fetch and load/store.
module cycle_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int CW      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] instr_in,
   input  logic       mem_ack,
   input  logic       acc_zero,
   output logic [2:0] opcode,
   output logic [4:0] immediate,
   output logic       mem_req,
   output logic       mem_sc,
   output logic       memWE,
   output logic       pc_en,
   output logic       brnch,
   output logic       regWE,
   output logic       lw,
   output logic       accWE,
   output logic       acc_sc,
   output logic [1:0] cntr_alu,
   output logic       retire,
   output logic       halted,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_FETCH  = 3'b001,
      S_DECODE = 3'b010,
      S_EXEC   = 3'b011,
      S_MEM    = 3'b100,
      S_WB     = 3'b101,
      S_HALT   = 3'b110,
      S_FAULT  = 3'b111
   } state_t;

   localparam logic [2:0] OP_LDI  = 3'b000;
   localparam logic [2:0] OP_LDA  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_SW   = 3'b110;
   localparam logic [2:0] OP_BEQZ = 3'b111;

   localparam logic [CW-1:0] TO = CW'(TIMEOUT);

   state_t        cur;
   state_t        nxt;
   logic [7:0]    ir;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   assign opcode    = ir[7:5];
   assign immediate = ir[4:0];
   assign state     = cur;

   // State, instruction and wait-counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= S_IDLE;
         ir  <= '0;
         cnt <= '0;
      end else begin
         cur <= nxt;
         cnt <= cnt_nxt;
         if (cur == S_FETCH && mem_ack)
            ir <= instr_in;
      end
   end

   // Next state; the wait counter only survives while a request stays unanswered
   always_comb begin
      nxt     = cur;
      cnt_nxt = '0;
      case (cur)
         S_IDLE: if (start) nxt = S_FETCH;
         S_FETCH: begin
            if (mem_ack)        nxt = S_DECODE;
            else if (cnt == TO) nxt = S_FAULT;
            else                cnt_nxt = cnt + CW'(1);
         end
         S_DECODE: begin
            if (opcode == OP_LW || opcode == OP_SW)
               nxt = S_MEM;
            else if (opcode == OP_BEQZ && immediate == 5'd0)
               nxt = S_HALT;
            else
               nxt = S_EXEC;
         end
         S_EXEC: nxt = S_FETCH;
         S_MEM: begin
            if (mem_ack)        nxt = (opcode == OP_LW) ? S_WB : S_FETCH;
            else if (cnt == TO) nxt = S_FAULT;
            else                cnt_nxt = cnt + CW'(1);
         end
         S_WB:    nxt = S_FETCH;
         S_HALT:  if (start) nxt = S_FETCH;
         S_FAULT: nxt = S_FAULT;
         default: nxt = S_IDLE;
      endcase
   end

   // Strobe decode; everything is forced low while reset is sampled
   always_comb begin
      mem_req  = 1'b0;
      mem_sc   = 1'b0;
      memWE    = 1'b0;
      pc_en    = 1'b0;
      brnch    = 1'b0;
      regWE    = 1'b0;
      lw       = 1'b0;
      accWE    = 1'b0;
      acc_sc   = 1'b0;
      cntr_alu = 2'b00;
      retire   = 1'b0;
      halted   = 1'b0;
      fault    = 1'b0;
      if (!reset) begin
         case (cur)
            S_FETCH: begin
               mem_req = 1'b1;
               pc_en   = mem_ack;
            end
            S_EXEC: begin
               retire = 1'b1;
               case (opcode)
                  OP_LDI: begin
                     accWE  = 1'b1;
                     acc_sc = 1'b1;
                  end
                  OP_LDA: accWE = 1'b1;
                  OP_ADD: regWE = 1'b1;
                  OP_SUB: begin
                     regWE    = 1'b1;
                     cntr_alu = 2'b01;
                  end
                  OP_AND: begin
                     regWE    = 1'b1;
                     cntr_alu = 2'b10;
                  end
                  OP_BEQZ: brnch = acc_zero;
                  default: ;
               endcase
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_sc  = 1'b1;
               if (opcode == OP_SW) begin
                  memWE  = mem_ack;
                  retire = mem_ack;
               end
            end
            S_WB: begin
               regWE  = 1'b1;
               lw     = 1'b1;
               retire = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: per-cycle vector table plus
// hand-written timeout, halt-restart and reset-during-store sequences.
module tb_cycle_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, mem_ack, acc_zero;
   logic [7:0] instr_in;
   logic [2:0] opcode, state;
   logic [4:0] immediate;
   logic       mem_req, mem_sc, memWE, pc_en, brnch, regWE, lw;
   logic       accWE, acc_sc, retire, halted, fault;
   logic [1:0] cntr_alu;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cycle_sequencer #(.TIMEOUT(15), .CW(8)) dut (
      .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
      .mem_ack(mem_ack), .acc_zero(acc_zero), .opcode(opcode),
      .immediate(immediate), .mem_req(mem_req), .mem_sc(mem_sc),
      .memWE(memWE), .pc_en(pc_en), .brnch(brnch), .regWE(regWE),
      .lw(lw), .accWE(accWE), .acc_sc(acc_sc), .cntr_alu(cntr_alu),
      .retire(retire), .halted(halted), .fault(fault), .state(state)
   );

   // strobe bit masks: {req,sc,we,pc,br,rw,lw,aw,as,alu[1:0],rt,hl,ft}
   localparam logic [13:0] REQ = 14'h2000, SC = 14'h1000, WE = 14'h0800;
   localparam logic [13:0] PC  = 14'h0400, BR = 14'h0200, RW = 14'h0100;
   localparam logic [13:0] LWS = 14'h0080, AW = 14'h0040, AS = 14'h0020;
   localparam logic [13:0] AL1 = 14'h0010, AL0 = 14'h0008, RT = 14'h0004;
   localparam logic [13:0] HL  = 14'h0002, FT = 14'h0001;

   localparam logic [2:0] IDLE = 3'd0, FET = 3'd1, DEC = 3'd2, EXE = 3'd3;
   localparam logic [2:0] MEM = 3'd4, WBK = 3'd5, HLT = 3'd6, FLT = 3'd7;

   wire [13:0] strb = {mem_req, mem_sc, memWE, pc_en, brnch, regWE, lw,
                       accWE, acc_sc, cntr_alu, retire, halted, fault};

   typedef struct {
      logic        rst;
      logic        st;
      logic [7:0]  ins;
      logic        ack;
      logic        az;
      logic [2:0]  est;
      logic [13:0] estb;
      logic [7:0]  eir;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic s, input logic [7:0] i,
                      input logic a, input logic z, input logic [2:0] es,
                      input logic [13:0] eb, input logic [7:0] ei);
      vec_t v;
      v.rst = r; v.st = s; v.ins = i; v.ack = a; v.az = z;
      v.est = es; v.estb = eb; v.eir = ei;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // drive one cycle's inputs away from the rising edge, let outputs settle
   task automatic cyc(input logic r, input logic s, input logic [7:0] i,
                      input logic a, input logic z);
      @(negedge clk);
      reset = r; start = s; instr_in = i; mem_ack = a; acc_zero = z;
      #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; instr_in = '0; mem_ack = 1'b0;
      acc_zero = 1'b0;
      repeat (2) @(posedge clk);

      add(1,0,8'h00,0,0, IDLE, 0,             8'h00);
      add(0,1,8'h00,0,0, IDLE, 0,             8'h00);
      add(0,0,8'h05,1,0, FET,  REQ|PC,        8'h00);
      add(0,0,8'h00,0,0, DEC,  0,             8'h05);
      add(0,0,8'h00,0,0, EXE,  AW|AS|RT,      8'h05);
      add(0,0,8'h43,1,0, FET,  REQ|PC,        8'h05);
      add(0,0,8'h00,0,0, DEC,  0,             8'h43);
      add(0,0,8'h00,0,0, EXE,  RW|RT,         8'h43);
      add(0,0,8'h63,1,0, FET,  REQ|PC,        8'h43);
      add(0,0,8'h00,0,0, DEC,  0,             8'h63);
      add(0,0,8'h00,0,0, EXE,  RW|AL0|RT,     8'h63);
      add(0,0,8'h81,1,0, FET,  REQ|PC,        8'h63);
      add(0,0,8'h00,0,0, DEC,  0,             8'h81);
      add(0,0,8'h00,0,0, EXE,  RW|AL1|RT,     8'h81);
      add(0,0,8'h20,1,0, FET,  REQ|PC,        8'h81);
      add(0,0,8'h00,0,0, DEC,  0,             8'h20);
      add(0,0,8'h00,0,0, EXE,  AW|RT,         8'h20);
      add(0,0,8'hA2,1,0, FET,  REQ|PC,        8'h20);
      add(0,0,8'h00,0,0, DEC,  0,             8'hA2);
      add(0,0,8'h00,0,0, MEM,  REQ|SC,        8'hA2);
      add(0,0,8'h00,0,0, MEM,  REQ|SC,        8'hA2);
      add(0,0,8'h00,1,0, MEM,  REQ|SC,        8'hA2);
      add(0,0,8'h00,0,0, WBK,  RW|LWS|RT,     8'hA2);
      add(0,0,8'hC2,1,0, FET,  REQ|PC,        8'hA2);
      add(0,0,8'h00,0,0, DEC,  0,             8'hC2);
      add(0,0,8'h00,1,0, MEM,  REQ|SC|WE|RT,  8'hC2);
      add(0,0,8'hE1,1,0, FET,  REQ|PC,        8'hC2);
      add(0,0,8'h00,0,1, DEC,  0,             8'hE1);
      add(0,0,8'h00,0,1, EXE,  BR|RT,         8'hE1);
      add(0,0,8'hE1,1,0, FET,  REQ|PC,        8'hE1);
      add(0,0,8'h00,0,0, DEC,  0,             8'hE1);
      add(0,0,8'h00,0,0, EXE,  RT,            8'hE1);
      add(0,0,8'hE0,1,0, FET,  REQ|PC,        8'hE1);
      add(0,0,8'h00,1,0, DEC,  0,             8'hE0);
      add(0,0,8'h00,1,1, HLT,  HL,            8'hE0);
      add(0,1,8'h00,0,0, HLT,  HL,            8'hE0);
      add(0,1,8'h00,0,0, FET,  REQ,           8'hE0);
      add(0,0,8'h01,1,0, FET,  REQ|PC,        8'hE0);
      add(0,1,8'h00,0,0, DEC,  0,             8'h01);
      add(0,0,8'h00,0,0, EXE,  AW|AS|RT,      8'h01);

      foreach (tbl[k]) begin
         cyc(tbl[k].rst, tbl[k].st, tbl[k].ins, tbl[k].ack, tbl[k].az);
         chk($sformatf("vec%0d_state", k), 32'(state), 32'(tbl[k].est));
         chk($sformatf("vec%0d_strobes", k), 32'(strb), 32'(tbl[k].estb));
         chk($sformatf("vec%0d_ir", k), 32'({opcode, immediate}),
             32'(tbl[k].eir));
      end

      // fetch never acknowledged: 16 FETCH cycles, then sticky FAULT
      cyc(1,0,8'h00,0,0);
      cyc(0,1,8'h00,0,0);
      for (int k = 0; k < 16; k++) begin
         cyc(0,0,8'h00,0,0);
         chk($sformatf("to_fetch%0d", k), 32'(state), 32'(FET));
      end
      for (int k = 0; k < 3; k++) begin
         cyc(0,1,8'h05,1,1);
         chk($sformatf("to_fault_state%0d", k), 32'(state), 32'(FLT));
         chk($sformatf("to_fault_strb%0d", k), 32'(strb), 32'(FT));
      end
      cyc(1,0,8'h00,0,0);
      cyc(0,0,8'h00,0,0);
      chk("fault_cleared", 32'({state, strb}), 32'({IDLE, 14'h0}));

      // ack arriving when the counter has reached TIMEOUT wins
      cyc(0,1,8'h00,0,0);
      for (int k = 0; k < 15; k++) cyc(0,0,8'h00,0,0);
      cyc(0,0,8'h07,1,0);
      chk("late_ack_strb", 32'({state, strb}), 32'({FET, REQ|PC}));
      cyc(0,0,8'h00,0,0);
      chk("late_ack_decode", 32'({state, strb}), 32'({DEC, 14'h0}));
      cyc(0,0,8'h00,0,0);
      chk("late_ack_exec", 32'({state, strb}), 32'({EXE, AW|AS|RT}));

      // reset during a pending store: no write strobe, IDLE next cycle
      cyc(1,0,8'h00,0,0);
      cyc(0,1,8'h00,0,0);
      cyc(0,0,8'hC2,1,0);
      cyc(0,0,8'h00,0,0);
      cyc(0,0,8'h00,0,0);
      chk("sw_mem_wait", 32'({state, strb}), 32'({MEM, REQ|SC}));
      cyc(1,0,8'h00,1,0);
      chk("sw_reset_strb", 32'(strb), 32'(0));
      cyc(0,0,8'h00,1,0);
      chk("sw_reset_idle", 32'({state, strb}), 32'({IDLE, 14'h0}));
      chk("sw_reset_ir", 32'({opcode, immediate}), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
